// File: rtl/issue_ctrl.sv
// Dual-issue instruction queue: 8-entry circular buffer between fetch
// and decode, with pair-issue gating from decode feedback.
module issue_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        fetch_valid_first,
  input  logic        fetch_valid_second,
  input  logic [31:0] fetch_instr_first,
  input  logic [31:0] fetch_instr_second,
  input  logic [31:0] fetch_pc_first,
  input  logic [31:0] fetch_pc_second,
  input  logic [13:0] fetch_exp_first,
  input  logic [13:0] fetch_exp_second,
  output logic        queue_full,
  input  logic        flush,
  input  logic        stall,
  output logic [31:0] Instr_First,
  output logic [31:0] Instr_Second,
  output logic [31:0] PC_First_out,
  output logic [31:0] PC_Second_out,
  output logic [13:0] Exp_First_out,
  output logic [13:0] Exp_Second_out,
  input  logic        is_Branch_Instr_first,
  input  logic        is_Branch_Instr_second,
  input  logic        is_Trap_Priv_Instr_first,
  input  logic        is_Trap_Priv_Instr_second,
  input  logic        is_HiLoRelated_Instr_first,
  input  logic        is_HiLoRelated_Instr_second,
  input  logic        Write_Reg_Enable_first,
  input  logic [4:0]  Write_Reg_Addr_first,
  input  logic [4:0]  rs_second,
  input  logic [4:0]  rt_second,
  input  logic [1:0]  LS_second,
  output logic        issue_valid_first,
  output logic        issue_valid_second,
  output logic [3:0]  queue_count
);

  logic [31:0] instr_q [8];
  logic [31:0] pc_q    [8];
  logic [13:0] exp_q   [8];

  logic [2:0] head;
  logic [2:0] tail;
  logic [3:0] count;
  logic [2:0] head_nx;
  logic [2:0] tail_nx;

  logic       enq_first;
  logic       enq_second;
  logic [3:0] enq_num;
  logic [3:0] deq_num;
  logic       has_one;
  logic       has_two;
  logic       ctrl_blk;
  logic       hilo_blk;
  logic       raw_blk;

  assign head_nx = head + 3'd1;
  assign tail_nx = tail + 3'd1;
  assign has_one = (count >= 4'd1);
  assign has_two = (count >= 4'd2);

  assign queue_full  = (count >= 4'd7);
  assign queue_count = count;

  assign enq_first  = fetch_valid_first & ~queue_full & ~flush;
  assign enq_second = enq_first & fetch_valid_second;
  assign enq_num    = {3'd0, enq_first} + {3'd0, enq_second};

  assign ctrl_blk = is_Branch_Instr_first | is_Trap_Priv_Instr_first
                  | is_Branch_Instr_second | is_Trap_Priv_Instr_second;
  assign hilo_blk = is_HiLoRelated_Instr_first
                  | is_HiLoRelated_Instr_second
                  | (LS_second != 2'b00);
  assign raw_blk  = Write_Reg_Enable_first
                  & (Write_Reg_Addr_first != 5'd0)
                  & ((Write_Reg_Addr_first == rs_second)
                   | (Write_Reg_Addr_first == rt_second));

  assign issue_valid_first  = has_one & ~stall & ~flush;
  assign issue_valid_second = issue_valid_first & has_two
                            & ~ctrl_blk & ~hilo_blk & ~raw_blk;
  assign deq_num = {3'd0, issue_valid_first} + {3'd0, issue_valid_second};

  // Empty slots present zeros so decode sees a NOP.
  assign Instr_First    = has_one ? instr_q[head] : 32'h0;
  assign PC_First_out   = has_one ? pc_q[head]    : 32'h0;
  assign Exp_First_out  = has_one ? exp_q[head]   : 14'h0;
  assign Instr_Second   = has_two ? instr_q[head_nx] : 32'h0;
  assign PC_Second_out  = has_two ? pc_q[head_nx]    : 32'h0;
  assign Exp_Second_out = has_two ? exp_q[head_nx]   : 14'h0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= 3'd0;
      tail  <= 3'd0;
      count <= 4'd0;
    end else if (flush) begin
      head  <= 3'd0;
      tail  <= 3'd0;
      count <= 4'd0;
    end else begin
      head  <= head + deq_num[2:0];
      tail  <= tail + enq_num[2:0];
      count <= count + enq_num - deq_num;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 8; i++) begin
        instr_q[i] <= 32'h0;
        pc_q[i]    <= 32'h0;
        exp_q[i]   <= 14'h0;
      end
    end else begin
      if (enq_first) begin
        instr_q[tail] <= fetch_instr_first;
        pc_q[tail]    <= fetch_pc_first;
        exp_q[tail]   <= fetch_exp_first;
      end
      if (enq_second) begin
        instr_q[tail_nx] <= fetch_instr_second;
        pc_q[tail_nx]    <= fetch_pc_second;
        exp_q[tail_nx]   <= fetch_exp_second;
      end
    end
  end

endmodule

// File: doc/issue_ctrl.md
ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports fetch_valid_first, fetch_valid_second, input, 1 each, fetch slot valid; second honoured only when first valid.
REQ-004 SHALL have ports fetch_instr_first/second (32), fetch_pc_first/second (32), fetch_exp_first/second (14), input, fetched instruction, PC, exception code.
REQ-005 SHALL have port queue_full, output, 1, high when fewer than 2 entries free (count >= 7).
REQ-006 SHALL have ports flush (1) and stall (1), input, pipeline flush / back-end stall.
REQ-007 SHALL have ports Instr_First, Instr_Second (32), PC_First_out, PC_Second_out (32), Exp_First_out, Exp_Second_out (14), output, queue head and head+1 toward decode.
REQ-008 SHALL have decode feedback inputs, 1 each: is_Branch_Instr_first/second, is_Trap_Priv_Instr_first/second, is_HiLoRelated_Instr_first/second, Write_Reg_Enable_first.
REQ-009 SHALL have decode feedback inputs Write_Reg_Addr_first, rs_second, rt_second (5 each) and LS_second (2).
REQ-010 SHALL have ports issue_valid_first, issue_valid_second, output, 1 each, slot issued this cycle.
REQ-011 SHALL have port queue_count, output, 4, current occupancy 0..8.

Function
REQ-012 SHALL hold an 8-entry circular FIFO of {instr, pc, exp}; 3-bit head/tail pointers wrap modulo 8.
REQ-013 SHALL drive head entry on *_First outputs when count >= 1, else all-zero (instr 32'h0 = NOP).
REQ-014 SHALL drive entry head+1 (mod 8) on *_Second outputs when count >= 2, else all-zero.
REQ-015 SHALL enqueue at edge: first at tail, second at tail+1; tail advances by number enqueued (0/1/2).
REQ-016 SHALL ignore fetch inputs when queue_full or flush high; fetch_valid_second without fetch_valid_first SHALL enqueue nothing.
REQ-017 SHALL assert issue_valid_first combinationally when count >= 1, stall low, flush low.
REQ-018 SHALL assert issue_valid_second only when issue_valid_first and count >= 2 and none of the block conditions REQ-019..REQ-021 hold.
REQ-019 Block: is_Branch_Instr_first, is_Trap_Priv_Instr_first, is_Branch_Instr_second or is_Trap_Priv_Instr_second high.
REQ-020 Block: is_HiLoRelated_Instr_first or is_HiLoRelated_Instr_second high, or LS_second != 2'b00.
REQ-021 Block (RAW): Write_Reg_Enable_first and Write_Reg_Addr_first != 0 and Write_Reg_Addr_first equals rs_second or rt_second.
REQ-022 SHALL advance head by issue_valid_first + issue_valid_second at the edge.
REQ-023 SHALL update count_next = count + enq - deq; simultaneous enqueue and dequeue in one cycle SHALL be exact.
REQ-024 SHALL on flush clear head, tail, count to 0 at the next edge, discarding same-cycle enqueue and issue.
REQ-025 SHALL never overflow (count <= 8) nor underflow (issue only from occupied entries).
REQ-026 queue_full and queue_count SHALL be derived from registered count only.

Reset
REQ-027 SHALL on resetn low, immediately and asynchronously: head=tail=0, count=0, all storage 0.
REQ-028 SHALL, while reset is asserted and after release, drive queue_count=0, queue_full=0, issue_valid_*=0, all data outputs 0 until first enqueue.
REQ-029 Reset asserted mid-operation SHALL discard all queued entries, no partial issue.

Verification
REQ-030 Reset then enqueue pair (0x24020001 @0xBFC00000, 0x24030002 @0xBFC00004), decode flags low -> next cycle count=2, both issue_valid high; following cycle count=0.
REQ-031 Head writes $2 (Write_Reg_Addr_first=2), rs_second=2 -> issue_valid_first=1, issue_valid_second=0, count drops by 1.
REQ-032 Fill 7 entries, stall high -> queue_full=1, fetch pair dropped, count stays 7, no issue.
REQ-033 Tail at 6, enqueue 2 while issuing 2 -> tail wraps to 0, count unchanged, order preserved across wrap.
REQ-034 Count=5, flush with fetch pair valid -> next cycle count=0, issue_valid_* low during flush cycle.
REQ-035 is_Branch_Instr_first=1, count=3 -> single issue; next cycle delay-slot instruction at head.
